// File: rtl/alu_result_stage.sv
// alu_result_stage: registered hand-off between the ALU execute units and
// register-file writeback. It holds up to two completed results in a small FIFO
// and owns the committed NZCV status register, which is fed back to the ALU.
module alu_result_stage #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned RD_BITS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [WIDTH-1:0]   result_i,
    input  logic [3:0]         new_flag_i,
    input  logic               s_i,
    input  logic [RD_BITS-1:0] rd_i,
    input  logic               wr_en_i,
    input  logic               flush_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [WIDTH-1:0]   out_result_o,
    output logic [RD_BITS-1:0] out_rd_o,
    output logic               out_wr_en_o,
    output logic [3:0]         flag_o
);

    localparam int unsigned EntryW = WIDTH + RD_BITS + 1;

    logic [EntryW-1:0] mem_q [2];
    logic [EntryW-1:0] last_q;
    logic [EntryW-1:0] head;
    logic [EntryW-1:0] out_entry;
    logic [1:0]        count_q, count_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [3:0]        flag_q, flag_d;
    logic              push, pop;

    // Handshake decode uses registered occupancy only, so no input reaches an output.
    assign in_ready_o  = (count_q != 2'd2);
    assign out_valid_o = (count_q != 2'd0);
    assign push        = in_valid_i & in_ready_o & ~flush_i;
    assign pop         = out_valid_o & out_ready_i;

    // When empty, outputs show the most recently popped entry instead of a stale slot.
    assign head      = mem_q[rd_ptr_q];
    assign out_entry = out_valid_o ? head : last_q;

    assign out_result_o = out_entry[EntryW-1 -: WIDTH];
    assign out_rd_o     = out_entry[RD_BITS:1];
    assign out_wr_en_o  = out_entry[0];
    assign flag_o       = flag_q;

    // Next-state for occupancy, pointers and the status register.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        flag_d   = flag_q;
        if (flush_i) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            if (push && !pop) begin
                count_d = count_q + 2'd1;
            end else if (pop && !push) begin
                count_d = count_q - 2'd1;
            end
        end
        // Flags commit at accept time; a later flush never rolls them back.
        if (push && s_i) begin
            flag_d = new_flag_i;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            flag_q   <= 4'b0000;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            flag_q   <= flag_d;
        end
    end

    // Entry storage and the last-delivered entry; a pop in a flush cycle still counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            last_q   <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {result_i, rd_i, wr_en_i};
            end
            if (pop) begin
                last_q <= head;
            end
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: a per-cycle vector table with
// hand-computed post-edge outputs, plus async-reset sequences.
module tb_alu_result_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] result_i;
    logic [3:0]  new_flag_i;
    logic        s_i;
    logic [3:0]  rd_i;
    logic        wr_en_i;
    logic        flush_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_result_o;
    logic [3:0]  out_rd_o;
    logic        out_wr_en_o;
    logic [3:0]  flag_o;

    int n_checks = 0;
    int n_fail   = 0;

    alu_result_stage #(
        .WIDTH  (32),
        .RD_BITS(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .result_i    (result_i),
        .new_flag_i  (new_flag_i),
        .s_i         (s_i),
        .rd_i        (rd_i),
        .wr_en_i     (wr_en_i),
        .flush_i     (flush_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_result_o(out_result_o),
        .out_rd_o    (out_rd_o),
        .out_wr_en_o (out_wr_en_o),
        .flag_o      (flag_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        iv;
        logic [31:0] res;
        logic [3:0]  nf;
        logic        s;
        logic [3:0]  rd;
        logic        we;
        logic        fl;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_res;
        logic [3:0]  e_rd;
        logic        e_we;
        logic [3:0]  e_flag;
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic ir, input logic ov,
                              input logic [31:0] res, input logic [3:0] rd, input logic we,
                              input logic [3:0] fl);
        check({tag, ".in_ready"},   {31'd0, in_ready_o},  {31'd0, ir});
        check({tag, ".out_valid"},  {31'd0, out_valid_o}, {31'd0, ov});
        check({tag, ".out_result"}, out_result_o,         res);
        check({tag, ".out_rd"},     {28'd0, out_rd_o},    {28'd0, rd});
        check({tag, ".out_wr_en"},  {31'd0, out_wr_en_o}, {31'd0, we});
        check({tag, ".flag"},       {28'd0, flag_o},      {28'd0, fl});
    endtask

    task automatic idle_inputs();
        in_valid_i  = 1'b0;
        result_i    = '0;
        new_flag_i  = '0;
        s_i         = 1'b0;
        rd_i        = '0;
        wr_en_i     = 1'b0;
        flush_i     = 1'b0;
        out_ready_i = 1'b0;
    endtask

    initial begin
        //              iv  res           nf       s     rd     we    fl    ordy  ir    ov    e_res         e_rd   e_we  e_flag
        // single op then drain
        vecs[0]  = '{1'b1, 32'd1,        4'b0000, 1'b1, 4'd3,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'd1,        4'd3,  1'b1, 4'b0000};
        vecs[1]  = '{1'b0, 32'd0,        4'b0000, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd1,        4'd3,  1'b1, 4'b0000};
        // flag gating: S=0 op leaves 0100 in place
        vecs[2]  = '{1'b1, 32'd0,        4'b0100, 1'b1, 4'd5,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0,        4'd5,  1'b1, 4'b0100};
        vecs[3]  = '{1'b1, 32'h007FFFFF, 4'b0010, 1'b0, 4'd6,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h007FFFFF, 4'd6,  1'b0, 4'b0100};
        vecs[4]  = '{1'b0, 32'd0,        4'b0000, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h007FFFFF, 4'd6,  1'b0, 4'b0100};
        // back-pressure: A, B accepted, C held until space
        vecs[5]  = '{1'b1, 32'd10,       4'b0000, 1'b0, 4'd1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'd10,       4'd1,  1'b1, 4'b0100};
        vecs[6]  = '{1'b1, 32'd20,       4'b0001, 1'b1, 4'd2,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd10,       4'd1,  1'b1, 4'b0001};
        vecs[7]  = '{1'b1, 32'd30,       4'b1111, 1'b1, 4'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd10,       4'd1,  1'b1, 4'b0001};
        vecs[8]  = '{1'b1, 32'd30,       4'b1111, 1'b1, 4'd3,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'd20,       4'd2,  1'b1, 4'b0001};
        vecs[9]  = '{1'b1, 32'd30,       4'b1111, 1'b1, 4'd3,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'd30,       4'd3,  1'b1, 4'b1111};
        vecs[10] = '{1'b0, 32'd0,        4'b0000, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd30,       4'd3,  1'b1, 4'b1111};
        // sustained push+pop at one entry
        vecs[11] = '{1'b1, 32'd40,       4'b0000, 1'b0, 4'd4,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'd40,       4'd4,  1'b1, 4'b1111};
        vecs[12] = '{1'b1, 32'd50,       4'b0000, 1'b0, 4'd5,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'd50,       4'd5,  1'b1, 4'b1111};
        vecs[13] = '{1'b1, 32'd60,       4'b0000, 1'b0, 4'd7,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'd60,       4'd7,  1'b1, 4'b1111};
        vecs[14] = '{1'b0, 32'd0,        4'b0000, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd60,       4'd7,  1'b1, 4'b1111};
        // flush while full drops the incoming op and its flags
        vecs[15] = '{1'b1, 32'd70,       4'b0000, 1'b0, 4'd8,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'd70,       4'd8,  1'b1, 4'b1111};
        vecs[16] = '{1'b1, 32'd80,       4'b0000, 1'b0, 4'd9,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd70,       4'd8,  1'b1, 4'b1111};
        vecs[17] = '{1'b1, 32'd90,       4'b1000, 1'b1, 4'd2,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd60,       4'd7,  1'b1, 4'b1111};
        // pop coincident with flush is delivered
        vecs[18] = '{1'b1, 32'd100,      4'b0000, 1'b0, 4'd10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'd100,      4'd10, 1'b1, 4'b1111};
        vecs[19] = '{1'b0, 32'd0,        4'b0000, 1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd100,      4'd10, 1'b1, 4'b1111};
        vecs[20] = '{1'b1, 32'd110,      4'b0011, 1'b1, 4'd11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'd110,      4'd11, 1'b1, 4'b0011};

        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_outs("reset", 1'b1, 1'b0, 32'd0, 4'd0, 1'b0, 4'b0000);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            in_valid_i  = vecs[i].iv;
            result_i    = vecs[i].res;
            new_flag_i  = vecs[i].nf;
            s_i         = vecs[i].s;
            rd_i        = vecs[i].rd;
            wr_en_i     = vecs[i].we;
            flush_i     = vecs[i].fl;
            out_ready_i = vecs[i].ordy;
            @(posedge clk);
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_res,
                       vecs[i].e_rd, vecs[i].e_we, vecs[i].e_flag);
        end

        // Asynchronous reset mid-cycle with one entry buffered and flags set.
        @(negedge clk);
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_reset", 1'b1, 1'b0, 32'd0, 4'd0, 1'b0, 4'b0000);

        // Release and confirm one-cycle latency from a clean state.
        @(negedge clk);
        rst_n       = 1'b1;
        in_valid_i  = 1'b1;
        result_i    = 32'hDEADBEEF;
        new_flag_i  = 4'b1010;
        s_i         = 1'b1;
        rd_i        = 4'd2;
        wr_en_i     = 1'b1;
        @(posedge clk);
        #1;
        check_outs("post_reset", 1'b1, 1'b1, 32'hDEADBEEF, 4'd2, 1'b1, 4'b1010);

        @(negedge clk);
        idle_inputs();
        out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        check_outs("post_reset_drain", 1'b1, 1'b0, 32'hDEADBEEF, 4'd2, 1'b1, 4'b1010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered result/flag stage directly downstream of the ALU execute units (ADD, LSR, etc.). Captures each ALU Result with its destination tag into a 2-entry buffer and hands it to register-file writeback over a valid/ready handshake. Owns the architectural NZCV status register: it commits New_Flag when S=1 and feeds the committed value back to the ALU Flag input.

## Interface
- WIDTH, 32, datapath width of Result
- RD_BITS, 4, width of destination register index
- Clk  in  1  clock, rising edge
- Rst_n  in  1  asynchronous, active-low reset
- In_Valid  in  1  ALU presents a completed operation
- In_Ready  out  1  stage can accept this cycle
- Result  in  WIDTH  ALU result
- New_Flag  in  4  ALU-computed flags, order [N,Z,C,V] (bit3..bit0)
- S  in  1  1 = operation updates status register
- Rd  in  RD_BITS  destination register index
- Wr_En  in  1  1 = operation writes Rd (0 for compare-type ops)
- Flush  in  1  discard all buffered entries
- Out_Valid  out  1  head entry available to writeback
- Out_Ready  in  1  writeback accepts head entry
- Out_Result  out  WIDTH  head entry result
- Out_Rd  out  RD_BITS  head entry destination
- Out_Wr_En  out  1  head entry write enable
- Flag  out  4  committed NZCV, [N,Z,C,V]

## Operation
- Push = In_Valid & In_Ready & !Flush. Pop = Out_Valid & Out_Ready.
- Buffer: 2-entry FIFO of {Result, Rd, Wr_En}; occupancy Count in {0,1,2}; write and read pointers 1 bit each, wrap 1->0.
- In_Ready = (Count != 2), combinational from registered Count only; never depends on Out_Ready.
- Out_Valid = (Count != 0); Out_Result/Out_Rd/Out_Wr_En driven from head entry; when Count==0 they hold the last popped values (0 after reset).
- Count update: push only +1; pop only -1; push and pop same cycle: unchanged (legal at Count==1; at Count==2 no push possible; at Count==0 no pop possible).
- Flag register: on Push with S=1, Flag <= New_Flag. Push with S=0 leaves Flag unchanged. Flag updates at accept time, independent of when the entry is popped.
- Entries with Wr_En=0 still occupy the buffer and are popped normally (writeback ignores them).
- Flush: Count, pointers cleared at next edge; In_Valid that cycle is dropped (no buffer write, no Flag update). A pop completing in the Flush cycle is considered delivered. Flag is never restored by Flush.
- Out_Ready with Out_Valid=0 has no effect. In_Valid with In_Ready=0 has no effect; upstream holds its data.

## Timing
- Reset (Rst_n=0, asynchronous): Count=0, pointers=0, Flag=4'b0000, Out_Valid=0, Out_Result=0, Out_Rd=0, Out_Wr_En=0, In_Ready=1. Reset mid-transfer drops all entries.
- Latency: entry pushed at edge k is on Out_* with Out_Valid=1 after edge k (visible in cycle k+1).
- Flag latency: Flag reflects New_Flag of a push at edge k from cycle k+1; the next ALU operation sees it with one-cycle latency.
- Throughput: 1 entry/cycle sustained when Out_Ready=1 continuously.
- Back-pressure: with Out_Ready=0, accepts exactly 2 entries, then In_Ready=0 from the cycle after the second push.
- All outputs registered or decoded from registered state only; no combinational In->Out path.

## Test plan
- Reset: Rst_n=0 mid-cycle -> immediately Flag=0000, Out_Valid=0, In_Ready=1, Out_Result=0.
- Single op: push Result=1, New_Flag=0000, S=1, Rd=3, Wr_En=1, Out_Ready=1 -> next cycle Out_Valid=1, Out_Result=1, Out_Rd=3, Flag=0000; following cycle Out_Valid=0.
- Flag gating: push Result=0, New_Flag=0100, S=1, then Result=0x007FFFFF, New_Flag=0010, S=0 -> Flag=0100 after both; second entry popped with Out_Result=0x007FFFFF.
- Back-pressure/wrap: Out_Ready=0, push A=10, B=20, C=30 back-to-back -> In_Ready=0 after B, C held; release Out_Ready -> outputs 10, 20, 30 in order, pointers wrap with no loss.
- Simultaneous push/pop at Count==1: Count stays 1, order preserved, Out_Result advances each cycle.
- Flush: Count=2, assert Flush with In_Valid=1, New_Flag=1000, S=1 -> next cycle Out_Valid=0, Count=0, Flag unchanged.
